updown_mod_counter: RTL and testbench

- Parametrised successor of the team's 16-bit reversible counter.
- Adds configurable width and modulus, count enable, synchronous parallel load, and a wrap/saturate mode select.
- Adds a sticky overflow flag, a zero flag and a cascadable terminal-count output (Rc).
- Used as a general counting/timebase element, and chained for multi-digit counters (for example BCD digits with MAX=9).

---
 rtl/updown_mod_counter.sv | 65 ++++++
 tb/tb_updown_mod_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter (0..MAX) with parallel load, wrap/saturate mode,
// sticky overflow, zero flag and a cascadable terminal-count output Rc.
module updown_mod_counter #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             at_top;
  logic             at_bot;
  logic             boundary;
  logic [WIDTH-1:0] cnt_next;

  // Cascade contract: Rc is high for exactly the cycle in which this stage
  // takes its boundary step, so a following stage with en=Rc steps on the
  // same clock edge.
  always_comb begin
    at_top   = (cnt == MAX);
    at_bot   = (cnt == '0);
    boundary = s ? at_top : at_bot;
    cnt_next = cnt;
    if (ld) begin
      cnt_next = (din > MAX) ? MAX : din;
    end else if (en) begin
      if (s) begin
        cnt_next = at_top ? (sat ? MAX : '0) : cnt + ONE;
      end else begin
        cnt_next = at_bot ? (sat ? '0 : MAX) : cnt - ONE;
      end
    end
  end

  assign Rc   = en & ~ld & ~rst & boundary;
  assign zero = (cnt == '0);

  // A boundary event on the same edge as clr_ovf keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (Rc) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: a 16-bit instance, a 4-bit MAX=9
// instance and a two-digit MAX=9 cascade, checked against an arithmetic model.
module tb_updown_mod_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit lane
  logic        r16 = 1'b0, e16 = 1'b0, s16 = 1'b0, l16 = 1'b0, t16 = 1'b0, c16 = 1'b0;
  logic [15:0] d16 = '0;
  logic [15:0] q16;
  logic        rc16, o16, z16;

  // 4-bit MAX=9 lane
  logic        r4 = 1'b0, e4 = 1'b0, s4 = 1'b0, l4 = 1'b0, t4 = 1'b0, c4 = 1'b0;
  logic [3:0]  d4 = '0;
  logic [3:0]  q4;
  logic        rc4, o4, z4;

  // cascade lane
  logic        rstc = 1'b0, ce = 1'b0;
  logic [3:0]  qa, qb;
  logic        rca, rcb, oa, ob, za, zb;

  updown_mod_counter dut16 (
    .clk(clk), .rst(r16), .en(e16), .s(s16), .ld(l16), .din(d16), .sat(t16),
    .clr_ovf(c16), .cnt(q16), .Rc(rc16), .ovf(o16), .zero(z16)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(4'd9)) dut4 (
    .clk(clk), .rst(r4), .en(e4), .s(s4), .ld(l4), .din(d4), .sat(t4),
    .clr_ovf(c4), .cnt(q4), .Rc(rc4), .ovf(o4), .zero(z4)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(4'd9)) stage0 (
    .clk(clk), .rst(rstc), .en(ce), .s(1'b1), .ld(1'b0), .din(4'd0), .sat(1'b0),
    .clr_ovf(1'b0), .cnt(qa), .Rc(rca), .ovf(oa), .zero(za)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(4'd9)) stage1 (
    .clk(clk), .rst(rstc), .en(rca), .s(1'b1), .ld(1'b0), .din(4'd0), .sat(1'b0),
    .clr_ovf(1'b0), .cnt(qb), .Rc(rcb), .ovf(ob), .zero(zb)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] q16;
    logic        o16;
    logic        rc16;
    logic [3:0]  q4;
    logic        o4;
    logic        rc4;
    logic [3:0]  qa;
    logic [3:0]  qb;
    logic        oa;
    logic        ob;
    logic        rca;
    logic        rcb;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int m16 = 0, mo16 = 0, m4 = 0, mo4 = 0;
  int mv = 0, moa = 0, mob = 0;

  // One edge of a counter with range 0..max, in plain integer arithmetic.
  function automatic void mstep(input int max, input int cur, input int ov,
                                input logic rst, input logic ld, input logic en,
                                input logic s, input logic sat, input logic clr,
                                input int din, output int nxt, output int novf,
                                output int rc);
    if (rst) begin
      nxt = 0; novf = 0; rc = 0;
    end else begin
      rc = (en && !ld && (s ? (cur == max) : (cur == 0))) ? 1 : 0;
      if (ld)       nxt = (din > max) ? max : din;
      else if (!en) nxt = cur;
      else if (s)   nxt = sat ? ((cur + 1 > max) ? max : cur + 1) : (cur + 1) % (max + 1);
      else          nxt = sat ? ((cur - 1 < 0) ? 0 : cur - 1) : (cur + max) % (max + 1);
      novf = rc ? 1 : (clr ? 0 : ov);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic tick;
    exp_t e;
    int   n, no, rc, d0, d1;
    logic rc0, rc1;
    mstep(65535, m16, mo16, r16, l16, e16, s16, t16, c16, int'(d16), n, no, rc);
    m16 = n; mo16 = no;
    e.q16 = 16'(n); e.o16 = (no != 0); e.rc16 = (rc != 0);
    mstep(9, m4, mo4, r4, l4, e4, s4, t4, c4, int'(d4), n, no, rc);
    m4 = n; mo4 = no;
    e.q4 = 4'(n); e.o4 = (no != 0); e.rc4 = (rc != 0);
    d0 = mv % 10;
    d1 = mv / 10;
    rc0 = !rstc && ce && (d0 == 9);
    rc1 = rc0 && (d1 == 9);
    if (rstc) begin
      mv = 0; moa = 0; mob = 0;
    end else begin
      if (rc0) moa = 1;
      if (rc1) mob = 1;
      if (ce)  mv = (mv + 1) % 100;
    end
    e.qa = 4'(mv % 10); e.qb = 4'(mv / 10);
    e.oa = (moa != 0); e.ob = (mob != 0);
    e.rca = rc0; e.rcb = rc1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle;
    r16 = 1'b0; e16 = 1'b0; l16 = 1'b0; c16 = 1'b0;
    r4  = 1'b0; e4  = 1'b0; l4  = 1'b0; c4  = 1'b0;
    rstc = 1'b0; ce = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Rc is combinational: capture it mid-cycle, after inputs settle.
  logic s_rc16, s_rc4, s_rca, s_rcb;
  always @(negedge clk) begin
    #2;
    s_rc16 = rc16; s_rc4 = rc4; s_rca = rca; s_rcb = rcb;
  end

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cnt16", 32'(q16), 32'(e.q16));
      chk("ovf16", 32'(o16), 32'(e.o16));
      chk("zero16", 32'(z16), 32'(e.q16 == 16'd0));
      chk("rc16", 32'(s_rc16), 32'(e.rc16));
      chk("cnt4", 32'(q4), 32'(e.q4));
      chk("ovf4", 32'(o4), 32'(e.o4));
      chk("zero4", 32'(z4), 32'(e.q4 == 4'd0));
      chk("rc4", 32'(s_rc4), 32'(e.rc4));
      chk("digit0", 32'(qa), 32'(e.qa));
      chk("digit1", 32'(qb), 32'(e.qb));
      chk("ovf_d0", 32'(oa), 32'(e.oa));
      chk("ovf_d1", 32'(ob), 32'(e.ob));
      chk("rc_d0", 32'(s_rca), 32'(e.rca));
      chk("rc_d1", 32'(s_rcb), 32'(e.rcb));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    // reset everything, then up-count on the 16-bit lane
    r16 = 1'b1; r4 = 1'b1; rstc = 1'b1;
    tick(); tick();
    idle();
    e16 = 1'b1; s16 = 1'b1; t16 = 1'b0;
    repeat (3) tick();
    idle();

    // wrap on MAX=9, then reverse from 0
    l4 = 1'b1; d4 = 4'd8; tick();
    l4 = 1'b0; e4 = 1'b1; s4 = 1'b1; t4 = 1'b0;
    tick(); tick();
    s4 = 1'b0; tick();
    idle();

    // saturate at both ends, clr_ovf vs boundary
    t4 = 1'b1; s4 = 1'b1; e4 = 1'b1;
    repeat (3) tick();
    e4 = 1'b0; l4 = 1'b1; d4 = 4'd0; tick();
    l4 = 1'b0; e4 = 1'b1; s4 = 1'b0;
    repeat (2) tick();
    c4 = 1'b1; tick();
    e4 = 1'b0; tick();
    c4 = 1'b0; t4 = 1'b0;

    // load clamp and priority
    l4 = 1'b1; d4 = 4'd13; tick();
    d4 = 4'd4; e4 = 1'b1; s4 = 1'b1; tick();
    e4 = 1'b0; r4 = 1'b1; tick();
    idle();

    // two-digit cascade
    ce = 1'b1;
    repeat (25) tick();
    idle();

    // mid-run reset on the 16-bit lane
    l16 = 1'b1; d16 = 16'h00FE; tick();
    l16 = 1'b0; e16 = 1'b1; s16 = 1'b1; tick();
    r16 = 1'b1; tick();
    r16 = 1'b0; tick();
    idle();

    // randomized traffic on all lanes
    for (int i = 0; i < 400; i++) begin
      r16 = ($urandom_range(0, 31) == 0);
      l16 = ($urandom_range(0, 5) == 0);
      e16 = ($urandom_range(0, 3) != 0);
      s16 = 1'($urandom_range(0, 1));
      t16 = 1'($urandom_range(0, 1));
      c16 = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0:       d16 = 16'h0000;
        1:       d16 = 16'h0001;
        2:       d16 = 16'hFFFE;
        3:       d16 = 16'hFFFF;
        default: d16 = 16'($urandom);
      endcase
      r4 = ($urandom_range(0, 31) == 0);
      l4 = ($urandom_range(0, 7) == 0);
      e4 = ($urandom_range(0, 3) != 0);
      s4 = 1'($urandom_range(0, 1));
      t4 = 1'($urandom_range(0, 1));
      c4 = ($urandom_range(0, 7) == 0);
      d4 = 4'($urandom_range(0, 15));
      rstc = ($urandom_range(0, 199) == 0);
      ce   = ($urandom_range(0, 4) != 0);
      tick();
    end
    idle();
    tick();

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
